// File: rtl/hex3_display_driver.sv
// rtl/hex3_display_driver.sv - binary to three-digit active-low seven-segment driver
//
// Converts an unsigned WIDTH-bit value to three decimal digits with a sequential
// shift-and-add-3 engine, then latches the segment patterns in one cycle so the
// display never shows partial results.
//
// Ports:
//   CLOCK_50 - system clock, rising edge
//   reset    - synchronous, active-high
//   value    - binary value, sampled only when a load is accepted
//   load     - start request, accepted only while idle
//   busy     - high while a conversion is in flight
//   done     - one-cycle pulse coincident with new HEX values
//   HEX0..2  - units/tens/hundreds, active-low, bit0=a .. bit6=g
module hex3_display_driver #(
    parameter int WIDTH    = 10,
    parameter bit BLANK_LZ = 1'b1
) (
    input  logic             CLOCK_50,
    input  logic             reset,
    input  logic [WIDTH-1:0] value,
    input  logic             load,
    output logic             busy,
    output logic             done,
    output logic [6:0]       HEX0,
    output logic [6:0]       HEX1,
    output logic [6:0]       HEX2
);

    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;
    localparam logic [6:0] SEG_ZERO  = 7'b1000000;
    localparam logic [6:0] HEX_HI_RST = BLANK_LZ ? SEG_BLANK : SEG_ZERO;
    localparam logic [WIDTH-1:0] MAX_DEC = WIDTH'(999);
    localparam logic [4:0] LAST_SHIFT = 5'(WIDTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_UPDATE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [11:0]      bcd_q, bcd_d;
    logic [11:0]      bcd_adj;
    logic [4:0]       cnt_q, cnt_d;
    logic             ovf_q, ovf_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [6:0]       hex0_q, hex0_d;
    logic [6:0]       hex1_q, hex1_d;
    logic [6:0]       hex2_q, hex2_d;

    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    seg7 = 7'b1000000;
            4'd1:    seg7 = 7'b1111001;
            4'd2:    seg7 = 7'b0100100;
            4'd3:    seg7 = 7'b0110000;
            4'd4:    seg7 = 7'b0011001;
            4'd5:    seg7 = 7'b0010010;
            4'd6:    seg7 = 7'b0000010;
            4'd7:    seg7 = 7'b1111000;
            4'd8:    seg7 = 7'b0000000;
            4'd9:    seg7 = 7'b0010000;
            default: seg7 = 7'b1111111;
        endcase
    endfunction

    // Add-3 correction on every nibble that would overflow past 9 after doubling.
    always_comb begin
        bcd_adj = bcd_q;
        for (int i = 0; i < 3; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) begin
                bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        bcd_d   = bcd_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        hex0_d  = hex0_q;
        hex1_d  = hex1_q;
        hex2_d  = hex2_q;

        case (state_q)
            ST_IDLE: begin
                if (load) begin
                    shreg_d = value;
                    bcd_d   = 12'd0;
                    cnt_d   = 5'd0;
                    ovf_d   = (value > MAX_DEC);
                    busy_d  = 1'b1;
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                // The thousands digit falls off the top; ovf covers that case.
                {bcd_d, shreg_d} = {bcd_adj, shreg_q} << 1;
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == LAST_SHIFT) begin
                    state_d = ST_UPDATE;
                end
            end
            ST_UPDATE: begin
                if (ovf_q) begin
                    hex2_d = SEG_DASH;
                    hex1_d = SEG_DASH;
                    hex0_d = SEG_DASH;
                end else begin
                    hex0_d = seg7(bcd_q[3:0]);
                    hex1_d = (BLANK_LZ && bcd_q[11:4] == 8'd0) ? SEG_BLANK : seg7(bcd_q[7:4]);
                    hex2_d = (BLANK_LZ && bcd_q[11:8] == 4'd0) ? SEG_BLANK : seg7(bcd_q[11:8]);
                end
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state_q <= ST_IDLE;
            shreg_q <= '0;
            bcd_q   <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            hex0_q  <= SEG_ZERO;
            hex1_q  <= HEX_HI_RST;
            hex2_q  <= HEX_HI_RST;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            bcd_q   <= bcd_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            hex0_q  <= hex0_d;
            hex1_q  <= hex1_d;
            hex2_q  <= hex2_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign HEX0 = hex0_q;
    assign HEX1 = hex1_q;
    assign HEX2 = hex2_q;

endmodule

// File: tb/tb_hex3_display_driver.sv
// tb/tb_hex3_display_driver.sv - directed self-checking bench for hex3_display_driver
module tb_hex3_display_driver;

    localparam logic [6:0] D0 = 7'b1000000;
    localparam logic [6:0] D1 = 7'b1111001;
    localparam logic [6:0] D2 = 7'b0100100;
    localparam logic [6:0] D3 = 7'b0110000;
    localparam logic [6:0] D4 = 7'b0011001;
    localparam logic [6:0] D5 = 7'b0010010;
    localparam logic [6:0] D6 = 7'b0000010;
    localparam logic [6:0] D7 = 7'b1111000;
    localparam logic [6:0] D8 = 7'b0000000;
    localparam logic [6:0] D9 = 7'b0010000;
    localparam logic [6:0] BL = 7'b1111111;
    localparam logic [6:0] DS = 7'b0111111;

    logic       CLOCK_50 = 1'b0;
    logic       reset    = 1'b1;
    logic [9:0] value    = '0;
    logic       load     = 1'b0;
    logic       busy;
    logic       done;
    logic [6:0] HEX0, HEX1, HEX2;

    int n_checks = 0;
    int n_errors = 0;

    hex3_display_driver #(.WIDTH(10), .BLANK_LZ(1'b1)) dut (
        .CLOCK_50 (CLOCK_50),
        .reset    (reset),
        .value    (value),
        .load     (load),
        .busy     (busy),
        .done     (done),
        .HEX0     (HEX0),
        .HEX1     (HEX1),
        .HEX2     (HEX2)
    );

    always #10 CLOCK_50 = ~CLOCK_50;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLOCK_50);
        #1;
    endtask

    task automatic check_hex(input string tag, input logic [6:0] e2, input logic [6:0] e1,
                             input logic [6:0] e0);
        check({tag, "_hex2"}, 32'(HEX2), 32'(e2));
        check({tag, "_hex1"}, 32'(HEX1), 32'(e1));
        check({tag, "_hex0"}, 32'(HEX0), 32'(e0));
    endtask

    // Loads v at the next edge (k), expects done exactly at k+11 with busy high until then.
    task automatic run_conv(input string tag, input logic [9:0] v, input logic [6:0] e2,
                            input logic [6:0] e1, input logic [6:0] e0);
        int lat;
        bit busy_ok;
        value = v;
        load  = 1'b1;
        tick();
        load    = 1'b0;
        value   = ~v;
        busy_ok = busy;
        lat     = 0;
        for (int i = 1; i <= 30; i++) begin
            tick();
            if (done) begin
                lat = i;
                break;
            end
            if (!busy) busy_ok = 1'b0;
        end
        check({tag, "_latency"}, 32'(lat), 32'd11);
        check({tag, "_busy_during"}, 32'(busy_ok), 32'd1);
        check({tag, "_busy_at_done"}, 32'(busy), 32'd0);
        check_hex(tag, e2, e1, e0);
        tick();
        check({tag, "_done_1cyc"}, 32'(done), 32'd0);
    endtask

    initial begin
        int dones;

        tick();
        tick();
        reset = 1'b0;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check_hex("rst", BL, BL, D0);

        run_conv("v7", 10'd7, BL, BL, D7);
        run_conv("v123", 10'd123, D1, D2, D3);
        run_conv("v105", 10'd105, D1, D0, D5);
        run_conv("v0", 10'd0, BL, BL, D0);
        run_conv("v999", 10'd999, D9, D9, D9);
        run_conv("v1000", 10'd1000, DS, DS, DS);
        run_conv("v1023", 10'd1023, DS, DS, DS);
        run_conv("v60", 10'd60, BL, D6, D0);

        // Reset pulse while idle with non-default display.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_hex("rst_mid", BL, BL, D0);
        check("rst_mid_busy", 32'(busy), 32'd0);

        // Load during busy is ignored: 456 at k, 789 at k+4.
        value = 10'd456;
        load  = 1'b1;
        tick();
        load  = 1'b0;
        dones = 0;
        for (int i = 1; i <= 11; i++) begin
            if (i == 4) begin
                value = 10'd789;
                load  = 1'b1;
            end
            tick();
            if (i == 4) load = 1'b0;
            if (done) dones++;
        end
        check("busy_load_done", 32'(done), 32'd1);
        check_hex("busy_load", D4, D5, D6);
        run_conv("v789", 10'd789, D7, D8, D9);
        check("busy_load_dones", 32'(dones), 32'd1);

        // Reset mid-conversion: 321 at k, reset sampled at k+5.
        value = 10'd321;
        load  = 1'b1;
        tick();
        load = 1'b0;
        for (int i = 1; i <= 4; i++) tick();
        reset = 1'b1;
        load  = 1'b1;
        tick();
        reset = 1'b0;
        load  = 1'b0;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check_hex("abort", BL, BL, D0);
        dones = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (done || busy) dones++;
        end
        check("abort_no_done", 32'(dones), 32'd0);
        run_conv("v42", 10'd42, BL, D4, D2);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
